// File: rtl/line_memory_ctrl.sv
// Backing-store line memory for the data cache refill/write-back port: one 128-bit line
// per request, completed after LATENCY cycles. Optional MEM_OOR_ERR_EN flags out-of-range addresses.
module line_memory_ctrl #(
    parameter int LINE_BITS   = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [LINE_BITS-1:0]  mem_writedata,
    output logic [LINE_BITS-1:0]  mem_readdata,
    output logic                  mem_ready
`ifdef MEM_OOR_ERR_EN
    ,
    output logic                  mem_err
`endif
);

    localparam int IW   = $clog2(DEPTH_LINES);
    localparam int CW   = $clog2(LATENCY + 1);
    localparam bit FAST = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic                 r_we;
    logic                 r_oor;
    logic [LINE_BITS-1:0] r_line;
    logic [LINE_BITS-1:0] r_mem [DEPTH_LINES];

    logic [IW-1:0]        w_idx_in;
    logic                 w_oor_in;
    logic                 w_unused;
    logic                 w_fin;
    logic                 w_commit;
    logic [IW-1:0]        w_f_idx;
    logic                 w_f_we;
    logic                 w_f_oor;
    logic [LINE_BITS-1:0] w_f_line;

    assign w_idx_in = memory_address[IW+3:4];
`ifdef MEM_OOR_ERR_EN
    assign w_oor_in = |memory_address[ADDR_WIDTH-1:IW+4];
    assign w_unused = ^memory_address[3:0];
`else
    // Upper bits are dropped so addresses alias modulo DEPTH_LINES.
    assign w_oor_in = 1'b0;
    assign w_unused = ^{memory_address[3:0], memory_address[ADDR_WIDTH-1:IW+4]};
`endif

    // With LATENCY=1 the request finishes on its acceptance edge, straight from the inputs.
    assign w_fin    = rst && (FAST ? (r_state == IDLE && mem_req)
                                   : (r_state == BUSY && r_cnt == CW'(1)));
    assign w_f_idx  = FAST ? w_idx_in      : r_idx;
    assign w_f_we   = FAST ? WriteEnable   : r_we;
    assign w_f_oor  = FAST ? w_oor_in      : r_oor;
    assign w_f_line = FAST ? mem_writedata : r_line;
    assign w_commit = w_fin && w_f_we && !w_f_oor;

    // Array is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit)
            r_mem[w_f_idx] <= w_f_line;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
            r_line       <= '0;
            mem_ready    <= 1'b0;
            mem_readdata <= '0;
`ifdef MEM_OOR_ERR_EN
            mem_err      <= 1'b0;
`endif
        end else begin
            mem_ready <= w_fin;
`ifdef MEM_OOR_ERR_EN
            mem_err   <= w_fin && w_f_oor;
`endif
            if (w_fin && !w_f_we)
                mem_readdata <= w_f_oor ? '0 : r_mem[w_f_idx];
            case (r_state)
                IDLE: begin
                    if (mem_req) begin
                        r_idx  <= w_idx_in;
                        r_we   <= WriteEnable;
                        r_oor  <= w_oor_in;
                        r_line <= mem_writedata;
                        if (FAST) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= RESP;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Randomized bench for line_memory_ctrl against a line-indexed reference model (LATENCY=4),
// plus a directed LATENCY=1 instance. Honours MEM_OOR_ERR_EN when defined.
module tb_line_memory_ctrl;

`ifdef MEM_OOR_ERR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req, we;
    logic [31:0]  addr;
    logic [127:0] wd, rd;
    logic         rdy, err;
    logic         req1, we1;
    logic [31:0]  addr1;
    logic [127:0] wd1, rd1;
    logic         rdy1, err1;

    int n_chk = 0;
    int n_bad = 0;

    logic [127:0] mdl [int];
    logic [127:0] last_rd;
    bit           last_known;

    always #5 clk = ~clk;

    line_memory_ctrl #(.LINE_BITS(128), .ADDR_WIDTH(32), .DEPTH_LINES(1024), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .mem_req(req), .WriteEnable(we), .memory_address(addr),
        .mem_writedata(wd), .mem_readdata(rd), .mem_ready(rdy)
`ifdef MEM_OOR_ERR_EN
        , .mem_err(err)
`endif
    );

    line_memory_ctrl #(.LINE_BITS(128), .ADDR_WIDTH(32), .DEPTH_LINES(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_req(req1), .WriteEnable(we1), .memory_address(addr1),
        .mem_writedata(wd1), .mem_readdata(rd1), .mem_ready(rdy1)
`ifdef MEM_OOR_ERR_EN
        , .mem_err(err1)
`endif
    );

`ifndef MEM_OOR_ERR_EN
    assign err  = 1'b0;
    assign err1 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete transaction on the LATENCY=4 instance, checked against the model.
    task automatic txn(input logic w, input logic [31:0] a, input logic [127:0] d, input bit drop);
        int  n;
        int  idx;
        bit  oor;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wd = d;
        @(posedge clk);
        #1;
        if (drop) begin
            req  = 1'b0;
            we   = ~w;
            addr = $urandom;
            wd   = {$urandom, $urandom, $urandom, $urandom};
        end
        n = 0;
        while (!rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req = 1'b0;
        chk("latency", 128'(n), 128'(3));
        idx = int'((a / 32'd16) % 32'd1024);
        oor = OOR && (a >= 32'h4000);
        if (rdy) begin
            chk("err", 128'(err), 128'(oor));
            if (w) begin
                if (last_known) chk("wr_hold", rd, last_rd);
                if (!oor) mdl[idx] = d;
            end else if (oor) begin
                chk("oor_rd", rd, 128'd0);
                last_rd = '0; last_known = 1'b1;
            end else if (mdl.exists(idx)) begin
                chk("rd_data", rd, mdl[idx]);
                last_rd = mdl[idx]; last_known = 1'b1;
            end else begin
                last_known = 1'b0;
            end
            @(posedge clk); #1;
            chk("pulse_w", 128'(rdy), 128'd0);
        end
    endtask

    initial begin
        bit any;
        logic [31:0]  a;
        logic [127:0] d;
        req = 0; we = 0; addr = 0; wd = 0;
        req1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
        last_rd = '0; last_known = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 128'(rdy), 128'd0);
        chk("rst_rd", rd, 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_rd1", rd1, 128'd0);
        @(negedge clk); rst = 1'b1;
        any = 0;
        repeat (10) begin
            @(posedge clk); #1;
            any |= rdy | rdy1;
        end
        chk("idle_rdy", 128'(any), 128'd0);

        // Directed write/read, sub-line offset on the read.
        txn(1'b1, 32'h0000_0040, 128'h44444444_33333333_22222222_11111111, 0);
        txn(1'b0, 32'h0000_004C, 128'h0, 0);
        chk("word0", 128'(rd[31:0]), 128'h11111111);

        // Reset mid-write: the aborted write must not land.
        txn(1'b1, 32'h0000_0080, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h80; wd = {4{32'hDEAD_BEEF}};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        any = 0;
        repeat (3) begin
            @(posedge clk); #1;
            any |= rdy;
        end
        chk("abort_rdy", 128'(any), 128'd0);
        @(negedge clk); rst = 1'b1;
        last_rd = '0; last_known = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            any |= rdy;
        end
        chk("abort_rdy2", 128'(any), 128'd0);
        txn(1'b0, 32'h0000_0080, 128'h0, 0);

        // Early mem_req drop still completes and commits.
        txn(1'b1, 32'h0000_00C0, {4{32'h0BAD_F00D}}, 1);
        txn(1'b0, 32'h0000_00C0, 128'h0, 0);

        // Out-of-range / aliasing.
        txn(1'b1, 32'h0000_0000, {4{32'h1234_5678}}, 0);
        txn(1'b1, 32'h0000_4000, {4{32'hCAFE_0001}}, 0);
        txn(1'b0, 32'h0000_4000, 128'h0, 0);
        txn(1'b0, 32'h0000_0000, 128'h0, 0);

        // Randomized traffic over a few lines, with upper-bit aliases.
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) a |= ($urandom_range(1, 3) << 14);
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(1'($urandom_range(0, 1)), a, d, bit'($urandom_range(0, 1)));
        end

        // LATENCY=1 instance: write then reads, mem_req held high throughout.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wd1 = {4{32'h7777_0001}};
        @(posedge clk); #1;
        chk("l1_wr_rdy", 128'(rdy1), 128'd1);
        we1 = 1'b0;
        @(posedge clk); #1;
        chk("l1_gap", 128'(rdy1), 128'd0);
        @(posedge clk); #1;
        chk("l1_rd_rdy", 128'(rdy1), 128'd1);
        chk("l1_rd_data", rd1, {4{32'h7777_0001}});
        @(posedge clk); #1;
        chk("l1_gap2", 128'(rdy1), 128'd0);
        @(posedge clk); #1;
        chk("l1_rd_rdy2", 128'(rdy1), 128'd1);
        req1 = 1'b0;
        @(posedge clk); #1;
        chk("l1_end", 128'(rdy1), 128'd0);
        @(posedge clk); #1;
        chk("l1_idle", 128'(rdy1), 128'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
